// File: rtl/softmax_job_sequencer.sv
// softmax_job_sequencer
//   Job-level controller for one softmax_core run. It loads input rows into the
//   core BRAM through port A, pulses the core start and waits out the busy
//   window. It then reads the result rows through port B (2-cycle read latency)
//   into a small skid FIFO and streams them out with valid/ready backpressure.
//
// Ports
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_job_start, i_cfg_depth  job request and its row count
//   o_job_busy/done/err       job status (done/err are one-cycle pulses)
//   i_in_valid/o_in_ready/i_in_data                  input row stream
//   o_out_valid/i_out_ready/o_out_data/o_out_last    result row stream
//   o_core_en, o_core_start, i_core_busy, o_core_depth  core control
//   o_core_cena/wea/addra/dina                       BRAM port A (write)
//   o_core_cenb/addrb, i_core_doutb                  BRAM port B (read)
//
// Build option
//   SOFTMAX_SEQ_TIMEOUT_EN : 16-bit watchdog on the core busy handshake.
module softmax_job_sequencer #(
  parameter int unsigned DW           = 1028,
  parameter int unsigned AW           = 8,
  parameter int unsigned MAX_DEPTH    = 17,
  parameter int unsigned START_CYCLES = 2,
  parameter int unsigned OFIFO_DEPTH  = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_job_start,
  input  logic [AW-1:0] i_cfg_depth,
  output logic          o_job_busy,
  output logic          o_job_done,
  output logic          o_job_err,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  input  logic [DW-1:0] i_in_data,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic [DW-1:0] o_out_data,
  output logic          o_out_last,
  output logic          o_core_en,
  output logic          o_core_start,
  input  logic          i_core_busy,
  output logic [AW-1:0] o_core_depth,
  output logic          o_core_cena,
  output logic          o_core_wea,
  output logic [AW-1:0] o_core_addra,
  output logic [DW-1:0] o_core_dina,
  output logic          o_core_cenb,
  output logic [AW-1:0] o_core_addrb,
  input  logic [DW-1:0] i_core_doutb
);

  localparam int unsigned PW = (OFIFO_DEPTH > 1) ? $clog2(OFIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(OFIFO_DEPTH + 1);
  localparam int unsigned SW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT_HI, S_WAIT_LO, S_DRAIN
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   depth_q, depth_d;
  logic [AW-1:0]   row_q, row_d;
  logic [SW-1:0]   scnt_q, scnt_d;
  logic [AW-1:0]   rd_addr_q, rd_addr_d;
  logic [AW-1:0]   out_idx_q, out_idx_d;
  logic            err_q, err_d;
  logic            done_q, done_d;
  logic            cena_q, cena_d;
  logic [AW-1:0]   addra_q, addra_d;
  logic [DW-1:0]   dina_q, dina_d;
  logic            core_en_q;

  logic [1:0]      rd_vld_q;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   cnt_q;
  logic [DW-1:0]   fifo_mem [OFIFO_DEPTH];

  logic            issue, push, pop, last_row;
  logic [CW:0]     occ;

`ifdef SOFTMAX_SEQ_TIMEOUT_EN
  logic [15:0]     wd_q, wd_d;
`endif

  // Reads in flight are reserved FIFO slots, so the FIFO can never overflow.
  assign occ      = {1'b0, cnt_q} + (CW+1)'(rd_vld_q[0]) + (CW+1)'(rd_vld_q[1]);
  assign issue    = (state_q == S_DRAIN) && (rd_addr_q < depth_q) &&
                    (occ < (CW+1)'(OFIFO_DEPTH));
  assign push     = rd_vld_q[1];
  assign pop      = o_out_valid && i_out_ready;
  assign last_row = (out_idx_q == depth_q - AW'(1));

  assign o_job_busy   = (state_q != S_IDLE);
  assign o_job_done   = done_q;
  assign o_job_err    = err_q;
  assign o_in_ready   = (state_q == S_LOAD);
  assign o_out_valid  = (cnt_q != '0);
  assign o_out_data   = o_out_valid ? fifo_mem[rd_ptr_q] : '0;
  assign o_out_last   = o_out_valid && last_row;
  assign o_core_en    = core_en_q;
  assign o_core_start = (state_q == S_START);
  assign o_core_depth = depth_q;
  assign o_core_cena  = cena_q;
  assign o_core_wea   = cena_q;
  assign o_core_addra = addra_q;
  assign o_core_dina  = dina_q;
  assign o_core_cenb  = issue;
  assign o_core_addrb = issue ? rd_addr_q : '0;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(OFIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    state_d   = state_q;
    depth_d   = depth_q;
    row_d     = row_q;
    scnt_d    = scnt_q;
    rd_addr_d = rd_addr_q;
    out_idx_d = out_idx_q;
    err_d     = 1'b0;
    done_d    = 1'b0;
    cena_d    = 1'b0;
    addra_d   = addra_q;
    dina_d    = dina_q;
    case (state_q)
      S_IDLE: begin
        if (i_job_start) begin
          if (i_cfg_depth == '0 || i_cfg_depth > AW'(MAX_DEPTH)) begin
            err_d = 1'b1;
          end else begin
            depth_d = i_cfg_depth;
            row_d   = '0;
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (i_in_valid) begin
          cena_d  = 1'b1;
          addra_d = row_q;
          dina_d  = i_in_data;
          row_d   = row_q + AW'(1);
          if (row_q == depth_q - AW'(1)) begin
            state_d = S_START;
            scnt_d  = '0;
          end
        end
      end
      S_START: begin
        if (scnt_q == SW'(START_CYCLES - 1)) state_d = S_WAIT_HI;
        else                                 scnt_d  = scnt_q + SW'(1);
      end
      S_WAIT_HI: if (i_core_busy) state_d = S_WAIT_LO;
      S_WAIT_LO: begin
        if (!i_core_busy) begin
          state_d   = S_DRAIN;
          rd_addr_d = '0;
          out_idx_d = '0;
        end
      end
      S_DRAIN: begin
        if (issue) rd_addr_d = rd_addr_q + AW'(1);
        if (pop) begin
          out_idx_d = out_idx_q + AW'(1);
          if (last_row) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef SOFTMAX_SEQ_TIMEOUT_EN
    // Trip one count early so the error pulse lands as the count hits FFFF.
    if ((state_q == S_WAIT_HI || state_q == S_WAIT_LO) &&
        state_d == state_q && wd_q == 16'hFFFE) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
    end
    if (state_d != state_q)                                   wd_d = '0;
    else if (state_q == S_WAIT_HI || state_q == S_WAIT_LO)    wd_d = wd_q + 16'd1;
    else                                                      wd_d = '0;
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      depth_q   <= '0;
      row_q     <= '0;
      scnt_q    <= '0;
      rd_addr_q <= '0;
      out_idx_q <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      cena_q    <= 1'b0;
      addra_q   <= '0;
      dina_q    <= '0;
      core_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      depth_q   <= depth_d;
      row_q     <= row_d;
      scnt_q    <= scnt_d;
      rd_addr_q <= rd_addr_d;
      out_idx_q <= out_idx_d;
      err_q     <= err_d;
      done_q    <= done_d;
      cena_q    <= cena_d;
      addra_q   <= addra_d;
      dina_q    <= dina_d;
      core_en_q <= 1'b1;
    end
  end

`ifdef SOFTMAX_SEQ_TIMEOUT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) wd_q <= '0;
    else          wd_q <= wd_d;
  end
`endif

  // Read pipeline tracker and skid FIFO control; reset drops in-flight reads.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_vld_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_vld_q <= {rd_vld_q[0], issue};
      if (push) wr_ptr_q <= ptr_next(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_next(rd_ptr_q);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) fifo_mem[wr_ptr_q] <= i_core_doutb;
  end

endmodule

// File: tb/tb_softmax_job_sequencer.sv
module tb_softmax_job_sequencer;

  localparam int DW = 1028;
  localparam int AW = 8;
  localparam int MAXD = 17;
  localparam int SC = 2;
  localparam int OFD = 4;

  logic          clk, i_rst_n;
  logic          i_job_start;
  logic [AW-1:0] i_cfg_depth;
  logic          o_job_busy, o_job_done, o_job_err;
  logic          i_in_valid, o_in_ready;
  logic [DW-1:0] i_in_data;
  logic          o_out_valid, i_out_ready, o_out_last;
  logic [DW-1:0] o_out_data;
  logic          o_core_en, o_core_start, i_core_busy;
  logic [AW-1:0] o_core_depth, o_core_addra, o_core_addrb;
  logic          o_core_cena, o_core_wea, o_core_cenb;
  logic [DW-1:0] o_core_dina, i_core_doutb;

  softmax_job_sequencer #(
    .DW(DW), .AW(AW), .MAX_DEPTH(MAXD), .START_CYCLES(SC), .OFIFO_DEPTH(OFD)
  ) dut (
    .i_clk(clk), .i_rst_n(i_rst_n),
    .i_job_start(i_job_start), .i_cfg_depth(i_cfg_depth),
    .o_job_busy(o_job_busy), .o_job_done(o_job_done), .o_job_err(o_job_err),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_data(i_in_data),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_out_data(o_out_data), .o_out_last(o_out_last),
    .o_core_en(o_core_en), .o_core_start(o_core_start), .i_core_busy(i_core_busy),
    .o_core_depth(o_core_depth),
    .o_core_cena(o_core_cena), .o_core_wea(o_core_wea),
    .o_core_addra(o_core_addra), .o_core_dina(o_core_dina),
    .o_core_cenb(o_core_cenb), .o_core_addrb(o_core_addrb),
    .i_core_doutb(i_core_doutb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core BRAM model: port A write, port B read with 2-cycle latency.
  logic [DW-1:0] mem [256];
  logic [DW-1:0] rp0, rp1;
  always @(posedge clk) begin
    if (o_core_cena && o_core_wea) mem[o_core_addra] <= o_core_dina;
    if (o_core_cenb) rp0 <= mem[o_core_addrb];
    rp1 <= rp0;
  end
  assign i_core_doutb = rp1;

  typedef struct { logic [DW-1:0] data; logic last; } out_t;
  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  out_t exp_out[$];
  wr_t  exp_wr[$];

  int n_chk = 0, n_fail = 0;
  int rows_out = 0, rd_issued = 0, done_cnt = 0, err_cnt = 0;
  int start_pulses = 0, start_run = 0, porta_cnt = 0, portb_cnt = 0;
  int mcyc = 0, first_pop = 0, last_pop = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    logic [63:0] a, e;
    a = act[63:0];
    e = exp[63:0];
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got low64 %h, expected low64 %h (t=%0t)", name, a, e, $time);
    end
  endtask

  function automatic logic [DW-1:0] rand_row();
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < (DW + 31) / 32; i++) r = {r[DW-33:0], 32'($urandom())};
    return r;
  endfunction

  // Monitor / scoreboard: pops expectations whenever the DUT presents activity.
  always @(negedge clk) begin
    mcyc++;
    if (!i_rst_n) begin
      start_run = 0;
    end else begin
      if (o_core_cena) begin
        porta_cnt++;
        chk("port_exclusive", o_core_cenb, 0);
        if (exp_wr.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          wr_t w;
          w = exp_wr.pop_front();
          chk("wr_addr", o_core_addra, w.addr);
          chk("wr_we", o_core_wea, 1);
          chk_data("wr_data", o_core_dina, w.data);
        end
      end
      if (o_core_cenb) begin
        portb_cnt++;
        chk("rd_addr", o_core_addrb, rd_issued);
        chk("rd_while_busy", i_core_busy, 0);
        rd_issued++;
        chk("fifo_bound", (rd_issued - rows_out) <= OFD, 1);
      end
      if (o_out_valid && i_out_ready) begin
        if (rows_out == 0) first_pop = mcyc;
        last_pop = mcyc;
        rows_out++;
        if (exp_out.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          out_t e;
          e = exp_out.pop_front();
          chk_data("out_data", o_out_data, e.data);
          chk("out_last", o_out_last, e.last);
        end
      end
      if (o_job_done) begin
        done_cnt++;
        chk("done_busy_low", o_job_busy, 0);
      end
      if (o_job_err) err_cnt++;
      if (o_core_start) start_run++;
      else if (start_run != 0) begin
        chk("start_width", start_run, SC);
        start_pulses++;
        start_run = 0;
      end
    end
  end

  task automatic start_job(input int d);
    rd_issued = 0;
    rows_out = 0;
    start_pulses = 0;
    @(posedge clk); #1;
    i_job_start = 1'b1;
    i_cfg_depth = AW'(d);
    @(posedge clk); #1;
    i_job_start = 1'b0;
    chk("busy_after_accept", o_job_busy, 1);
    chk("core_depth", o_core_depth, d);
  endtask

  task automatic load_rows(input int d, input bit gaps);
    int idx, guard;
    logic [DW-1:0] row;
    out_t o;
    wr_t w;
    idx = 0;
    guard = 0;
    while (idx < d && guard < 40 * d + 40) begin
      i_in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      row = rand_row();
      i_in_data = row;
      @(negedge clk);
      if (i_in_valid && o_in_ready) begin
        w.addr = idx[AW-1:0];
        w.data = row;
        exp_wr.push_back(w);
        o.data = row;
        o.last = (idx == d - 1);
        exp_out.push_back(o);
        idx++;
      end
      @(posedge clk); #1;
      guard++;
    end
    i_in_valid = 1'b0;
    chk("rows_loaded", idx, d);
    chk("in_ready_dropped", o_in_ready, 0);
  endtask

  // Entered in the first START cycle.
  task automatic busy_phase(input int delay, input int len, input bit early, input bit probe);
    if (!early) repeat (SC + delay) begin @(posedge clk); #1; end
    i_core_busy = 1'b1;
    if (probe) begin
      i_job_start = 1'b1;
      i_cfg_depth = '0;
      @(posedge clk); #1;
      i_job_start = 1'b0;
    end
    repeat (len) begin @(posedge clk); #1; end
    i_core_busy = 1'b0;
  endtask

  task automatic drain_wait(input int d, input int mode);
    int cyc, d0;
    cyc = 0;
    d0 = done_cnt;
    while (done_cnt == d0 && cyc < 2000) begin
      case (mode)
        0:       i_out_ready = 1'b1;
        1:       i_out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: i_out_ready = 1'($urandom_range(0, 1));
      endcase
      @(posedge clk); #1;
      cyc++;
    end
    i_out_ready = 1'b0;
    chk("done_seen", done_cnt - d0, 1);
    chk("rows_out", rows_out, d);
    chk("rd_count", rd_issued, d);
    chk("exp_out_empty", exp_out.size(), 0);
    chk("start_pulses", start_pulses, 1);
    chk("busy_after_done", o_job_busy, 0);
    if (mode == 0) chk("throughput", last_pop - first_pop, d - 1);
    repeat (3) begin @(posedge clk); #1; end
    chk("single_done", done_cnt - d0, 1);
  endtask

  task automatic run_job(input int d, input int delay, input int len, input int mode,
                         input bit early, input bit gaps, input bit probe);
    int e0;
    e0 = err_cnt;
    start_job(d);
    load_rows(d, gaps);
    busy_phase(delay, len, early, probe);
    drain_wait(d, mode);
    chk("no_err_in_job", err_cnt - e0, 0);
    chk("depth_held", o_core_depth, d);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int e0, pa0, pb0, g;
    i_rst_n = 1'b0; i_job_start = 1'b0; i_cfg_depth = '0; i_in_valid = 1'b0;
    i_in_data = '0; i_out_ready = 1'b0; i_core_busy = 1'b0;
    #12;
    chk("rst_busy", o_job_busy, 0);
    chk("rst_en", o_core_en, 0);
    chk("rst_out_valid", o_out_valid, 0);
    chk("rst_in_ready", o_in_ready, 0);
    chk("rst_ports", {o_core_cena, o_core_cenb, o_core_start, o_job_done, o_job_err}, 0);
    @(posedge clk); #1;
    i_rst_n = 1'b1;
    chk("en_before_edge", o_core_en, 0);
    @(posedge clk); #1;
    chk("en_after_release", o_core_en, 1);

    // Rejected starts: depth 0 and MAX_DEPTH+1.
    e0 = err_cnt; pa0 = porta_cnt; pb0 = portb_cnt;
    for (int k = 0; k < 2; k++) begin
      i_job_start = 1'b1;
      i_cfg_depth = (k == 0) ? AW'(0) : AW'(MAXD + 1);
      @(posedge clk); #1;
      i_job_start = 1'b0;
      chk("reject_err_pulse", o_job_err, 1);
      chk("reject_busy", o_job_busy, 0);
      @(posedge clk); #1;
      chk("reject_err_clear", o_job_err, 0);
      chk("reject_busy2", o_job_busy, 0);
    end
    repeat (3) begin @(posedge clk); #1; end
    chk("reject_err_count", err_cnt - e0, 2);
    chk("reject_no_porta", porta_cnt - pa0, 0);
    chk("reject_no_portb", portb_cnt - pb0, 0);

    // Nominal, with a start request during the busy window that must be ignored.
    run_job(17, 3, 50, 0, 1'b0, 1'b0, 1'b1);
    // Backpressure 1,0,0,1.
    run_job(4, 2, 10, 1, 1'b0, 1'b0, 1'b0);
    // Busy rises during START.
    run_job(5, 0, 8, 0, 1'b1, 1'b0, 1'b0);
    // Minimum depth.
    run_job(1, 1, 4, 0, 1'b0, 1'b0, 1'b0);
    // Randomized jobs.
    for (int j = 0; j < 5; j++)
      run_job($urandom_range(1, MAXD), $urandom_range(0, 5), $urandom_range(1, 20), 2,
              1'($urandom_range(0, 1)), 1'b1, 1'b0);

    // Reset mid-drain.
    start_job(8);
    load_rows(8, 1'b0);
    busy_phase(1, 5, 1'b0, 1'b0);
    i_out_ready = 1'b1;
    g = 0;
    while (rows_out < 2 && g < 300) begin @(negedge clk); #1; g++; end
    chk("reached_row2", rows_out >= 2, 1);
    #1 i_rst_n = 1'b0;
    #1;
    chk("arst_busy", o_job_busy, 0);
    chk("arst_out_valid", o_out_valid, 0);
    chk("arst_en", o_core_en, 0);
    chk("arst_depth", o_core_depth, 0);
    chk("arst_ports", {o_core_cena, o_core_cenb, o_core_start, o_in_ready, o_out_last}, 0);
    exp_out.delete();
    exp_wr.delete();
    i_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 i_rst_n = 1'b1;
    @(posedge clk); #1;
    chk("en_after_rerelease", o_core_en, 1);
    run_job(3, 2, 6, 0, 1'b0, 1'b0, 1'b0);

`ifdef SOFTMAX_SEQ_TIMEOUT_EN
    e0 = err_cnt;
    start_job(1);
    load_rows(1, 1'b0);
    repeat (SC) begin @(posedge clk); #1; end
    g = 0;
    while (!o_job_err && g < 70000) begin @(posedge clk); #1; g++; end
    chk("timeout_cycles", g, 65535);
    chk("timeout_busy", o_job_busy, 0);
    chk("timeout_no_reads", rd_issued, 0);
    repeat (3) begin @(posedge clk); #1; end
    chk("timeout_err_once", err_cnt - e0, 1);
    exp_out.delete();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/softmax_job_sequencer.md
Name: softmax_job_sequencer

Overview:
- Job-level controller that sequences one softmax_core run: streams input rows into the core BRAM through port A, starts the core and waits out its busy window.
- Then reads result rows from port B, which has 2-cycle read latency, and streams them out with valid/ready backpressure.
- Sits between the system stream fabric and softmax_core, replacing bench-driven BRAM access.

Parameters:
- DW, 1028, row width in bits (core BRAM word).
- AW, 8, BRAM address width.
- MAX_DEPTH, 17, largest accepted row count.
- START_CYCLES, 2, width of o_core_start pulse in clocks.
- OFIFO_DEPTH, 4, output skid FIFO entries; must be ≥3.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_job_start  in  1  pulse; latches i_cfg_depth and begins a job.
- i_cfg_depth  in  AW  rows per job.
- o_job_busy  out  1  high from job accept to final output handshake.
- o_job_done  out  1  one-cycle pulse after last output row accepted.
- o_job_err  out  1  one-cycle pulse on rejected start.
- i_in_valid / o_in_ready / i_in_data  in/out/in  1/1/DW  input row stream.
- o_out_valid / i_out_ready / o_out_data / o_out_last  out/in/out/out  1/1/DW/1  result row stream.
- o_core_en  out  1  core enable.
- o_core_start  out  1  core start pulse.
- i_core_busy  in  1  core busy.
- o_core_depth  out  AW  latched depth.
- o_core_cena, o_core_wea  out  1  port A enable and write enable.
- o_core_addra  out  AW  port A address.
- o_core_dina  out  DW  port A write data.
- o_core_cenb  out  1  port B enable.
- o_core_addrb  out  AW  port B address.
- i_core_doutb  in  DW  port B read data, valid 2 cycles after cenb.

Behaviour:
- Reset: all outputs 0 except o_core_en=1, which goes high on the first clock after reset release. State IDLE; counters and FIFO cleared.
- Reset asserted mid-job aborts immediately. In-flight reads are discarded. No o_job_done is issued.
- IDLE:
  - o_in_ready=0.
  - i_job_start with 1 ≤ depth ≤ MAX_DEPTH latches depth to o_core_depth, clears the row counter, goes to LOAD, and asserts o_job_busy the next cycle.
  - depth=0 or depth>MAX_DEPTH pulses o_job_err and stays IDLE.
  - i_job_start outside IDLE is ignored.
- LOAD:
  - o_in_ready=1.
  - Each i_in_valid&o_in_ready cycle registers cena=wea=1, addra=row, dina=data for one clock, then increments row.
  - After row depth-1 is written, go to START and drop o_in_ready in the same cycle as the last handshake.
- START: o_core_start high for START_CYCLES clocks, then WAIT_HI.
- WAIT_HI: wait for i_core_busy=1, then WAIT_LO.
  - If busy is already high during START, WAIT_HI exits on the first cycle.
- WAIT_LO: wait for i_core_busy=0, then DRAIN with read address 0.
- DRAIN:
  - Issue cenb=1, addrb=rd_addr in a cycle only when (FIFO count + reads in flight) < OFIFO_DEPTH and rd_addr < depth.
  - A 2-stage valid shift register tracks in-flight reads. Data is captured into the FIFO exactly 2 cycles after issue.
  - Output is the FIFO head. o_out_last is high on output row depth-1.
  - Back-to-back reads give 1 row/clock throughput when i_out_ready is held high.
  - Simultaneous FIFO push and pop keeps the count unchanged.
  - The FIFO never overflows under any i_out_ready pattern.
- After the last-row handshake: o_job_done pulse, o_job_busy=0, return to IDLE.
- Port A and port B are never enabled in the same cycle.

Optional Feature:
- Macro: SOFTMAX_SEQ_TIMEOUT_EN.
- When defined:
  - A 16-bit watchdog counts cycles in WAIT_HI and WAIT_LO.
  - Reaching 16'hFFFF pulses o_job_err, deasserts o_job_busy and returns to IDLE without draining.
  - The watchdog clears on each state entry.
- When undefined: no watchdog; WAIT_HI and WAIT_LO wait indefinitely.

Test Plan:
- Nominal: depth=17, 17 rows written, busy high 50 cycles, i_out_ready=1.
  - Required: addra 0..16, one start pulse of 2 cycles, 17 output rows matching golden data, o_out_last on row 16, o_job_done once.
- Backpressure: depth=4, i_out_ready toggling 1,0,0,1 repeating.
  - Required: no lost or duplicated rows, rows in address order, FIFO count never exceeds 4.
- Reject: i_job_start with depth=0, then with depth=18.
  - Required: o_job_err pulses twice, o_job_busy stays 0, no core port activity.
- Busy early: i_core_busy rises during START.
  - Required: sequencer still reaches DRAIN only after busy falls; no reads are issued while busy=1.
- Reset mid-DRAIN: i_rst_n=0 at output row 2 of 8.
  - Required: all outputs return to reset values asynchronously; after release, a new depth=3 job completes with exactly 3 rows.
- Timeout (macro defined): i_core_busy never rises.
  - Required: o_job_err 65535 cycles after WAIT_HI entry, return to IDLE, no port B reads.
